// File: rtl/laser_pkg.sv
// Shared types and constants for the laser beacon tower emulator.
// Phase-to-AB encoding, FSM states and default geometry.
package laser_pkg;

  localparam int unsigned DEF_TICKS_PER_REV = 360;
  localparam int unsigned DEF_NUM_BEACONS   = 3;
  localparam int unsigned POS_W             = 16;
  localparam int unsigned DIV_W             = 16;

  // Quarter-step phase p -> {A,B}
  localparam logic [1:0] AB_P0 = 2'b00;
  localparam logic [1:0] AB_P1 = 2'b10;
  localparam logic [1:0] AB_P2 = 2'b11;
  localparam logic [1:0] AB_P3 = 2'b01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  function automatic logic [1:0] phase_to_ab(input logic [1:0] p);
    logic [1:0] ab;
    case (p)
      2'd0:    ab = AB_P0;
      2'd1:    ab = AB_P1;
      2'd2:    ab = AB_P2;
      default: ab = AB_P3;
    endcase
    return ab;
  endfunction

endpackage

// File: rtl/laser_beacon_window.sv
// Wrap-aware angular window compare for one beacon.
// Bounds at or beyond the revolution length never match.
module laser_beacon_window
  import laser_pkg::*;
#(
  parameter int unsigned TICKS_PER_REV = DEF_TICKS_PER_REV
) (
  input  logic [POS_W-1:0] pos_i,
  input  logic [POS_W-1:0] start_i,
  input  logic [POS_W-1:0] end_i,
  input  logic             en_i,
  output logic             hit_o
);

  localparam logic [POS_W-1:0] LIMIT = POS_W'(TICKS_PER_REV);

  logic bounds_ok;
  logic in_win;

  always_comb begin
    bounds_ok = (start_i < LIMIT) && (end_i < LIMIT);
    if (start_i <= end_i) in_win = (pos_i >= start_i) && (pos_i <= end_i);
    else                  in_win = (pos_i >= start_i) || (pos_i <= end_i);
    hit_o = en_i && bounds_ok && in_win;
  end

endmodule

// File: rtl/laser_tower_emulator.sv
// Emulates the rotating laser beacon tower: quadrature A/B, revolution sync
// and active-low beacon return, driven from a programmable step rate.
module laser_tower_emulator
  import laser_pkg::*;
#(
  parameter int unsigned TICKS_PER_REV = DEF_TICKS_PER_REV,
  parameter int unsigned NUM_BEACONS   = DEF_NUM_BEACONS
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         direction,
  input  logic [15:0]                  clk_div,
  input  logic [NUM_BEACONS-1:0]       beacon_en,
  input  logic [NUM_BEACONS*16-1:0]    beacon_start,
  input  logic [NUM_BEACONS*16-1:0]    beacon_end,
  output logic                         laser_cod_a,
  output logic                         laser_cod_b,
  output logic                         laser_sync,
  output logic                         laser_signal,
  output logic [15:0]                  position,
  output logic [15:0]                  rev_count
);

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(TICKS_PER_REV - 1);

  state_e state_q, state_d;
  logic   run_c, load_c;

  // Shadow configuration, only refreshed on start and at revolution wrap
  logic                       dir_q;
  logic [DIV_W-1:0]           div_q;
  logic [NUM_BEACONS-1:0]     ben_q;
  logic [NUM_BEACONS*16-1:0]  bstart_q;
  logic [NUM_BEACONS*16-1:0]  bend_q;

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [1:0]       phase_q, phase_d;
  logic [1:0]       ab_q, ab_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [15:0]      rev_q, rev_d;
  logic             sync_q, sync_d;
  logic [1:0]       left_q, left_d;
  logic             sig_q, sig_d;

  logic [DIV_W-1:0]       div_max_c;
  logic                   step_c, wrap_c, load_cfg_c, sync_start_c;
  logic [NUM_BEACONS-1:0] hit_c;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable)  state_d = RUN;
      RUN:     if (!enable) state_d = PAUSE;
      PAUSE:   if (enable)  state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    run_c  = 1'b0;
    load_c = 1'b0;
    case (state_q)
      IDLE:    load_c = enable;
      RUN:     run_c  = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    div_max_c = (div_q < DIV_W'(2)) ? DIV_W'(1) : div_q - DIV_W'(1);
    step_c    = run_c && (cnt_q == div_max_c);
  end

  // Divider, phase, position and revolution counters
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    ab_d    = ab_q;
    pos_d   = pos_q;
    rev_d   = rev_q;
    wrap_c  = 1'b0;
    if (run_c) begin
      if (step_c) begin
        cnt_d   = '0;
        phase_d = dir_q ? phase_q + 2'd1 : phase_q - 2'd1;
        ab_d    = phase_to_ab(phase_d);
        if (dir_q && phase_d == 2'd2) begin
          wrap_c = (pos_q == LAST_POS);
          pos_d  = wrap_c ? '0 : pos_q + POS_W'(1);
        end else if (!dir_q && phase_d == 2'd3) begin
          wrap_c = (pos_q == '0);
          pos_d  = wrap_c ? LAST_POS : pos_q - POS_W'(1);
        end
        if (wrap_c) rev_d = rev_q + 16'd1;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  assign load_cfg_c = load_c || wrap_c;

  for (genvar k = 0; k < NUM_BEACONS; k++) begin : g_win
    laser_beacon_window #(
      .TICKS_PER_REV(TICKS_PER_REV)
    ) u_win (
      .pos_i  (pos_d),
      .start_i(bstart_q[k*16 +: 16]),
      .end_i  (bend_q[k*16 +: 16]),
      .en_i   (ben_q[k]),
      .hit_o  (hit_c[k])
    );
  end

  // Sync opens two quarter-steps ahead of the wrapping B rise and lasts four
  always_comb begin
    sync_d       = sync_q;
    left_d       = left_q;
    sig_d        = sig_q;
    sync_start_c = dir_q ? (phase_d == 2'd0 && pos_d == LAST_POS)
                         : (phase_d == 2'd1 && pos_d == '0);
    if (step_c) begin
      sig_d = ~(|hit_c);
      if (sync_start_c) begin
        sync_d = 1'b1;
        left_d = 2'd3;
      end else if (left_q != 2'd0) begin
        sync_d = 1'b1;
        left_d = left_q - 2'd1;
      end else begin
        sync_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_q    <= 1'b0;
      div_q    <= '0;
      ben_q    <= '0;
      bstart_q <= '0;
      bend_q   <= '0;
      cnt_q    <= '0;
      phase_q  <= 2'd0;
      ab_q     <= AB_P0;
      pos_q    <= '0;
      rev_q    <= '0;
      sync_q   <= 1'b0;
      left_q   <= 2'd0;
      sig_q    <= 1'b1;
    end else begin
      if (load_cfg_c) begin
        dir_q    <= direction;
        div_q    <= clk_div;
        ben_q    <= beacon_en;
        bstart_q <= beacon_start;
        bend_q   <= beacon_end;
      end
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      ab_q    <= ab_d;
      pos_q   <= pos_d;
      rev_q   <= rev_d;
      sync_q  <= sync_d;
      left_q  <= left_d;
      sig_q   <= sig_d;
    end
  end

  assign laser_cod_a  = ab_q[1];
  assign laser_cod_b  = ab_q[0];
  assign laser_sync   = sync_q;
  assign laser_signal = sig_q;
  assign position     = pos_q;
  assign rev_count    = rev_q;

endmodule

// File: tb/tb_laser_tower_emulator.sv
// Directed bench for laser_tower_emulator with an 8-tick revolution.
// Checkpoints are clock counts after the IDLE->RUN edge.
module tb_laser_tower_emulator;

  localparam int unsigned NB = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          direction;
  logic [15:0]   clk_div;
  logic [NB-1:0] beacon_en;
  logic [NB*16-1:0] beacon_start;
  logic [NB*16-1:0] beacon_end;
  logic          laser_cod_a, laser_cod_b, laser_sync, laser_signal;
  logic [15:0]   position, rev_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cur_t    = 0;

  typedef struct {
    int          scen;
    int          t;
    logic [1:0]  ab;
    logic [15:0] pos;
    logic        sync;
    logic        sig;
    logic [15:0] rev;
  } vec_t;

  vec_t vecs[$];

  laser_tower_emulator #(
    .TICKS_PER_REV(8),
    .NUM_BEACONS  (NB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .direction   (direction),
    .clk_div     (clk_div),
    .beacon_en   (beacon_en),
    .beacon_start(beacon_start),
    .beacon_end  (beacon_end),
    .laser_cod_a (laser_cod_a),
    .laser_cod_b (laser_cod_b),
    .laser_sync  (laser_sync),
    .laser_signal(laser_signal),
    .position    (position),
    .rev_count   (rev_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int t, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d actual=%0h expected=%0h", name, t, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] ab, input logic [15:0] pos,
                         input logic sync, input logic sig, input logic [15:0] rev);
    chk({tag, ".ab"},   cur_t, {14'd0, laser_cod_a, laser_cod_b}, {14'd0, ab});
    chk({tag, ".pos"},  cur_t, position, pos);
    chk({tag, ".sync"}, cur_t, {15'd0, laser_sync}, {15'd0, sync});
    chk({tag, ".sig"},  cur_t, {15'd0, laser_signal}, {15'd0, sig});
    chk({tag, ".rev"},  cur_t, rev_count, rev);
  endtask

  task automatic set_cfg(input int s);
    case (s)
      0: begin
        direction = 1'b1; clk_div = 16'd2; beacon_en = 3'b001;
        beacon_start = {16'd0, 16'd0, 16'd2};
        beacon_end   = {16'd7, 16'd7, 16'd4};
      end
      1: begin
        direction = 1'b1; clk_div = 16'd0; beacon_en = 3'b011;
        beacon_start = {16'd0, 16'd2, 16'd6};
        beacon_end   = {16'd7, 16'd9, 16'd1};
      end
      default: begin
        direction = 1'b0; clk_div = 16'd2; beacon_en = 3'b000;
        beacon_start = {16'd0, 16'd0, 16'd2};
        beacon_end   = {16'd7, 16'd7, 16'd4};
      end
    endcase
  endtask

  task automatic start_run(input int s);
    reset  = 1'b1;
    enable = 1'b0;
    set_cfg(s);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    @(posedge clk);
    #1 cur_t = 0;
  endtask

  task automatic advance_to(input int t);
    if (t > cur_t) begin
      repeat (t - cur_t) @(posedge clk);
      #1;
    end
    cur_t = t;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0;
    set_cfg(0);

    // forward, beacon (2,4), D=2
    vecs.push_back('{0,  0, 2'b00, 16'd0, 1'b0, 1'b1, 16'd0});
    vecs.push_back('{0,  2, 2'b10, 16'd0, 1'b0, 1'b1, 16'd0});
    vecs.push_back('{0,  4, 2'b11, 16'd1, 1'b0, 1'b1, 16'd0});
    vecs.push_back('{0,  8, 2'b00, 16'd1, 1'b0, 1'b1, 16'd0});
    vecs.push_back('{0, 12, 2'b11, 16'd2, 1'b0, 1'b0, 16'd0});
    vecs.push_back('{0, 20, 2'b11, 16'd3, 1'b0, 1'b0, 16'd0});
    vecs.push_back('{0, 28, 2'b11, 16'd4, 1'b0, 1'b0, 16'd0});
    vecs.push_back('{0, 36, 2'b11, 16'd5, 1'b0, 1'b1, 16'd0});
    vecs.push_back('{0, 55, 2'b01, 16'd7, 1'b0, 1'b1, 16'd0});
    vecs.push_back('{0, 56, 2'b00, 16'd7, 1'b1, 1'b1, 16'd0});
    vecs.push_back('{0, 60, 2'b11, 16'd0, 1'b1, 1'b1, 16'd1});
    vecs.push_back('{0, 63, 2'b01, 16'd0, 1'b1, 1'b1, 16'd1});
    vecs.push_back('{0, 64, 2'b00, 16'd0, 1'b0, 1'b1, 16'd1});
    // clk_div=0, wrapped window (6,1), out-of-range window (2,9)
    vecs.push_back('{1,  5, 2'b11, 16'd1, 1'b0, 1'b0, 16'd0});
    vecs.push_back('{1, 13, 2'b11, 16'd2, 1'b0, 1'b1, 16'd0});
    vecs.push_back('{1, 21, 2'b11, 16'd3, 1'b0, 1'b1, 16'd0});
    vecs.push_back('{1, 29, 2'b11, 16'd4, 1'b0, 1'b1, 16'd0});
    vecs.push_back('{1, 37, 2'b11, 16'd5, 1'b0, 1'b1, 16'd0});
    vecs.push_back('{1, 45, 2'b11, 16'd6, 1'b0, 1'b0, 16'd0});
    vecs.push_back('{1, 53, 2'b11, 16'd7, 1'b0, 1'b0, 16'd0});
    vecs.push_back('{1, 61, 2'b11, 16'd0, 1'b1, 1'b0, 16'd1});
    // reverse
    vecs.push_back('{2,  0, 2'b00, 16'd0, 1'b0, 1'b1, 16'd0});
    vecs.push_back('{2,  2, 2'b01, 16'd7, 1'b0, 1'b1, 16'd1});
    vecs.push_back('{2,  4, 2'b11, 16'd7, 1'b0, 1'b1, 16'd1});
    vecs.push_back('{2,  6, 2'b10, 16'd7, 1'b0, 1'b1, 16'd1});
    vecs.push_back('{2,  8, 2'b00, 16'd7, 1'b0, 1'b1, 16'd1});
    vecs.push_back('{2, 10, 2'b01, 16'd6, 1'b0, 1'b1, 16'd1});
    vecs.push_back('{2, 61, 2'b11, 16'd0, 1'b0, 1'b1, 16'd1});
    vecs.push_back('{2, 62, 2'b10, 16'd0, 1'b1, 1'b1, 16'd1});
    vecs.push_back('{2, 66, 2'b01, 16'd7, 1'b1, 1'b1, 16'd2});
    vecs.push_back('{2, 69, 2'b11, 16'd7, 1'b1, 1'b1, 16'd2});
    vecs.push_back('{2, 70, 2'b10, 16'd7, 1'b0, 1'b1, 16'd2});

    for (int s = 0; s < 3; s++) begin
      start_run(s);
      foreach (vecs[i]) begin
        if (vecs[i].scen == s) begin
          advance_to(vecs[i].t);
          chk_all($sformatf("vec%0d", i), vecs[i].ab, vecs[i].pos,
                  vecs[i].sync, vecs[i].sig, vecs[i].rev);
        end
      end
    end

    // Beacon window change mid-revolution only takes effect after the wrap
    start_run(0);
    advance_to(21);
    chk("cfg.pos3", cur_t, position, 16'd3);
    beacon_start[15:0] = 16'd5;
    advance_to(37);
    chk("cfg.pos5", cur_t, position, 16'd5);
    chk("cfg.sig5", cur_t, {15'd0, laser_signal}, 16'd1);
    advance_to(53);
    chk("cfg.sig7", cur_t, {15'd0, laser_signal}, 16'd1);
    advance_to(69);
    chk("cfg.pos1", cur_t, position, 16'd1);
    chk("cfg.sig1", cur_t, {15'd0, laser_signal}, 16'd0);

    // Enable low for 10 clocks mid-count: frozen, then resumes with count intact
    start_run(0);
    advance_to(12);
    chk_all("pause.pre", 2'b11, 16'd2, 1'b0, 1'b0, 16'd0);
    enable = 1'b0;
    advance_to(15);
    chk_all("pause.hold1", 2'b11, 16'd2, 1'b0, 1'b0, 16'd0);
    advance_to(22);
    chk_all("pause.hold2", 2'b11, 16'd2, 1'b0, 1'b0, 16'd0);
    enable = 1'b1;
    advance_to(23);
    chk("pause.t23.ab", cur_t, {14'd0, laser_cod_a, laser_cod_b}, 16'h3);
    advance_to(24);
    chk("pause.t24.ab", cur_t, {14'd0, laser_cod_a, laser_cod_b}, 16'h1);
    advance_to(30);
    chk("pause.t30.ab", cur_t, {14'd0, laser_cod_a, laser_cod_b}, 16'h3);
    chk("pause.t30.pos", cur_t, position, 16'd3);

    // Asynchronous reset mid-run, then IDLE holds until enable
    start_run(1);
    advance_to(61);
    chk_all("prerst", 2'b11, 16'd0, 1'b1, 1'b0, 16'd1);
    reset = 1'b1;
    #1;
    chk_all("rst", 2'b00, 16'd0, 1'b0, 1'b1, 16'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    enable = 1'b0;
    set_cfg(0);
    repeat (6) @(posedge clk);
    #1;
    chk_all("idle", 2'b00, 16'd0, 1'b0, 1'b1, 16'd0);
    @(negedge clk);
    enable = 1'b1;
    @(posedge clk);
    #1 cur_t = 0;
    advance_to(1);
    chk("restart.t1.ab", cur_t, {14'd0, laser_cod_a, laser_cod_b}, 16'h0);
    advance_to(2);
    chk("restart.t2.ab", cur_t, {14'd0, laser_cod_a, laser_cod_b}, 16'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
